// File: rtl/lc3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lc3_pkg                                                    |
// | Description : Shared register-file geometry and types for the LC-3 core. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package lc3_pkg;

    localparam int REG_W      = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef logic [REG_W-1:0]      reg_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                 |
// | Description : Combinational round-robin arbiter with a rotating pointer. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr_q;
    logic [PTR_W-1:0] w_ptr_d;
    logic [N-1:0]     w_grant;
    logic             w_found;

    // Search starts at the pointer and wraps; the sum of pointer and offset
    // stays below 2*N, so one conditional subtraction is enough for the wrap.
    always_comb begin
        w_grant = '0;
        w_ptr_d = r_ptr_q;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [PTR_W:0] idx;
            idx = {1'b0, r_ptr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N)) begin
                idx = idx - (PTR_W+1)'(N);
            end
            if (!w_found && req[idx[PTR_W-1:0]]) begin
                w_found                   = 1'b1;
                w_grant[idx[PTR_W-1:0]]   = 1'b1;
                if (idx == (PTR_W+1)'(N-1)) begin
                    w_ptr_d = '0;
                end else begin
                    w_ptr_d = idx[PTR_W-1:0] + 1'b1;
                end
            end
        end
        if (rst) begin
            w_grant = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/reg_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_wb_scheduler                                           |
// | Description : Round-robin writeback port sharing with a pending-write    |
// |               scoreboard for RAW hazard stalls. Optional macro           |
// |               WB_BYPASS_EN adds commit-cycle bypass outputs.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module reg_wb_scheduler
    import lc3_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [3*NREQ-1:0]       req_dr,
    input  logic [16*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    alloc_valid,
    input  logic [2:0]              alloc_dr,
    output logic                    alloc_ready,
    input  logic [2:0]              sr1,
    input  logic [2:0]              sr2,
    output logic                    sr1_busy,
    output logic                    sr2_busy,
    output logic                    wb_en,
    output logic [2:0]              wb_dr,
    output logic [15:0]             wb_data,
    output logic                    err_underflow
`ifdef WB_BYPASS_EN
    ,
    output logic                    byp1_hit,
    output logic                    byp2_hit,
    output logic [15:0]             byp1_data,
    output logic [15:0]             byp2_data
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [NREQ-1:0]   w_grant;
    logic              w_accept;
    reg_addr_t         w_sel_dr;
    reg_data_t         w_sel_data;

    logic              r_wb_en_q,   w_wb_en_d;
    reg_addr_t         r_wb_dr_q,   w_wb_dr_d;
    reg_data_t         r_wb_data_q, w_wb_data_d;
    logic              r_err_q,     w_err_d;
    logic [CNT_W-1:0]  r_cnt_q [NUM_REGS];
    logic [CNT_W-1:0]  w_cnt_d [NUM_REGS];
    logic              w_alloc_ready;
    logic              w_alloc_fire;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .grant (w_grant)
    );

    assign w_accept = |w_grant;

    // Grant is one-hot, so an OR-reduction over gated lanes acts as the mux.
    always_comb begin
        w_sel_dr   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_dr   = w_sel_dr   | req_dr[REG_ADDR_W*i +: REG_ADDR_W];
                w_sel_data = w_sel_data | req_data[REG_W*i +: REG_W];
            end
        end
    end

    always_comb begin
        w_wb_en_d   = w_accept;
        w_wb_dr_d   = w_accept ? w_sel_dr   : r_wb_dr_q;
        w_wb_data_d = w_accept ? w_sel_data : r_wb_data_q;
    end

    assign w_alloc_ready = !rst && (r_cnt_q[alloc_dr] != C_CNT_MAX);
    assign w_alloc_fire  = alloc_valid && w_alloc_ready;

    // The registered write port is the commit: it retires at the same edge
    // the register file captures the data.
    always_comb begin
        w_err_d = r_err_q | (r_wb_en_q && (r_cnt_q[r_wb_dr_q] == '0));
        for (int r = 0; r < NUM_REGS; r++) begin
            logic inc;
            logic dec;
            inc        = w_alloc_fire && (alloc_dr == REG_ADDR_W'(r));
            dec        = r_wb_en_q    && (r_wb_dr_q == REG_ADDR_W'(r));
            w_cnt_d[r] = r_cnt_q[r];
            if (inc && !dec) begin
                w_cnt_d[r] = r_cnt_q[r] + 1'b1;
            end else if (dec && !inc && (r_cnt_q[r] != '0)) begin
                w_cnt_d[r] = r_cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en_q   <= 1'b0;
            r_wb_dr_q   <= '0;
            r_wb_data_q <= '0;
            r_err_q     <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt_q[r] <= '0;
            end
        end else begin
            r_wb_en_q   <= w_wb_en_d;
            r_wb_dr_q   <= w_wb_dr_d;
            r_wb_data_q <= w_wb_data_d;
            r_err_q     <= w_err_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt_q[r] <= w_cnt_d[r];
            end
        end
    end

    assign req_ready     = w_grant;
    assign alloc_ready   = w_alloc_ready;
    assign sr1_busy      = (r_cnt_q[sr1] != '0);
    assign sr2_busy      = (r_cnt_q[sr2] != '0);
    assign wb_en         = r_wb_en_q;
    assign wb_dr         = r_wb_dr_q;
    assign wb_data       = r_wb_data_q;
    assign err_underflow = r_err_q;

`ifdef WB_BYPASS_EN
    assign byp1_hit  = r_wb_en_q && (r_wb_dr_q == sr1);
    assign byp2_hit  = r_wb_en_q && (r_wb_dr_q == sr2);
    assign byp1_data = r_wb_data_q;
    assign byp2_data = r_wb_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reg_wb_scheduler                                        |
// | Description : Directed self-checking bench for reg_wb_scheduler.         |
// |               Bypass checks are built when WB_BYPASS_EN is defined.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_reg_wb_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [8:0]  req_dr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        alloc_valid;
    logic [2:0]  alloc_dr;
    logic        alloc_ready;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        sr1_busy;
    logic        sr2_busy;
    logic        wb_en;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        err_underflow;
`ifdef WB_BYPASS_EN
    logic        byp1_hit;
    logic        byp2_hit;
    logic [15:0] byp1_data;
    logic [15:0] byp2_data;
`endif

    int checks = 0;
    int errors = 0;

    reg_wb_scheduler #(
        .NREQ  (3),
        .CNT_W (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_dr        (req_dr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .alloc_valid   (alloc_valid),
        .alloc_dr      (alloc_dr),
        .alloc_ready   (alloc_ready),
        .sr1           (sr1),
        .sr2           (sr2),
        .sr1_busy      (sr1_busy),
        .sr2_busy      (sr2_busy),
        .wb_en         (wb_en),
        .wb_dr         (wb_dr),
        .wb_data       (wb_data),
        .err_underflow (err_underflow)
`ifdef WB_BYPASS_EN
        ,
        .byp1_hit      (byp1_hit),
        .byp2_hit      (byp2_hit),
        .byp1_data     (byp1_data),
        .byp2_data     (byp2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_dr      = '0;
        req_data    = '0;
        alloc_valid = 1'b0;
        alloc_dr    = '0;
        sr1         = '0;
        sr2         = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst       = 1'b1;
        req_valid = 3'b111;
        alloc_valid = 1'b1;
        step();
        step();
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL reset_alloc_ready got %b want 0", alloc_ready); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
        checks++; if (wb_dr !== 3'd0) begin errors++; $display("FAIL reset_wb_dr got %0d want 0", wb_dr); end
        checks++; if (wb_data !== 16'h0000) begin errors++; $display("FAIL reset_wb_data got %h want 0000", wb_data); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_underflow); end
        clear_inputs();
        rst = 1'b0;
        sr1 = 3'd5;
        sr2 = 3'd0;
        #1;
        checks++; if (sr1_busy !== 1'b0 || sr2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b want 00", sr1_busy, sr2_busy); end
    endtask

    task automatic test_single_write();
        do_reset();
        req_valid   = 3'b001;
        req_dr      = 9'd2;
        req_data    = 48'h1234;
        alloc_valid = 1'b1;
        alloc_dr    = 3'd2;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b want 001", req_ready); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL single_alloc_ready got %b want 1", alloc_ready); end
        step();
        clear_inputs();
        sr1 = 3'd2;
        #1;
        checks++; if (wb_en !== 1'b1 || wb_dr !== 3'd2 || wb_data !== 16'h1234) begin errors++; $display("FAIL single_wb got en=%b dr=%0d data=%h want en=1 dr=2 data=1234", wb_en, wb_dr, wb_data); end
        checks++; if (sr1_busy !== 1'b1) begin errors++; $display("FAIL single_busy_pending got %b want 1", sr1_busy); end
        step();
        checks++; if (wb_en !== 1'b0 || wb_dr !== 3'd2 || wb_data !== 16'h1234) begin errors++; $display("FAIL single_wb_idle got en=%b dr=%0d data=%h want en=0 dr=2 data=1234", wb_en, wb_dr, wb_data); end
        checks++; if (sr1_busy !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("FAIL single_retired got busy=%b err=%b want 0 0", sr1_busy, err_underflow); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        do_reset();
        req_valid = 3'b111;
        req_dr    = {3'd3, 3'd2, 3'd1};
        req_data  = {16'hA002, 16'hA001, 16'hA000};
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            #1;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, exp_g); end
            step();
            checks++; if (wb_en !== 1'b1 || wb_dr !== 3'((k % 3) + 1) || wb_data !== 16'hA000 + 16'(k % 3)) begin
                errors++; $display("FAIL rr_wb[%0d] got en=%b dr=%0d data=%h want en=1 dr=%0d data=%h", k, wb_en, wb_dr, wb_data, (k % 3) + 1, 16'hA000 + 16'(k % 3));
            end
        end
        req_valid = 3'b110;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rr_skip0 got %b want 010", req_ready); end
        step();
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL rr_skip1 got %b want 100", req_ready); end
        step();
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rr_wrap got %b want 010", req_ready); end
        step();
        req_valid = 3'b000;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rr_idle_ready got %b want 000", req_ready); end
        step();
        checks++; if (wb_en !== 1'b0 || wb_dr !== 3'd2 || wb_data !== 16'hA001) begin errors++; $display("FAIL rr_idle_hold got en=%b dr=%0d data=%h want en=0 dr=2 data=a001", wb_en, wb_dr, wb_data); end
    endtask

    task automatic test_alloc_full();
        do_reset();
        alloc_valid = 1'b1;
        alloc_dr    = 3'd5;
        sr1         = 3'd5;
        step();
        step();
        step();
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after3 got %b want 0", alloc_ready); end
        checks++; if (sr1_busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b want 1", sr1_busy); end
        alloc_dr = 3'd4;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_other_reg_ready got %b want 1", alloc_ready); end
        alloc_dr  = 3'd5;
        req_valid = 3'b001;
        req_dr    = 9'd5;
        req_data  = 48'h0055;
        step();
        req_valid = 3'b000;
        #1;
        checks++; if (wb_en !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_stall got en=%b ready=%b want 1 0", wb_en, alloc_ready); end
        step();
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_after_commit got %b want 1", alloc_ready); end
        step();
        alloc_valid = 1'b0;
        #1;
        checks++; if (alloc_ready !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("FAIL full_refilled got ready=%b err=%b want 0 0", alloc_ready, err_underflow); end
    endtask

    task automatic test_hazard();
        do_reset();
        alloc_valid = 1'b1;
        alloc_dr    = 3'd3;
        step();
        alloc_valid = 1'b0;
        sr1 = 3'd3;
        sr2 = 3'd0;
        #1;
        checks++; if (sr1_busy !== 1'b1 || sr2_busy !== 1'b0) begin errors++; $display("FAIL haz_busy got %b%b want 10", sr1_busy, sr2_busy); end
        req_valid = 3'b001;
        req_dr    = 9'd3;
        req_data  = 48'h0333;
        step();
        req_valid = 3'b000;
        #1;
        checks++; if (sr1_busy !== 1'b1) begin errors++; $display("FAIL haz_busy_before_commit got %b want 1", sr1_busy); end
        step();
        checks++; if (sr1_busy !== 1'b0) begin errors++; $display("FAIL haz_busy_after_commit got %b want 0", sr1_busy); end
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        req_valid   = 3'b001;
        step();
        req_valid   = 3'b000;
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        #1;
        checks++; if (sr1_busy !== 1'b1) begin errors++; $display("FAIL haz_alloc_commit_same got %b want 1", sr1_busy); end
    endtask

    task automatic test_underflow();
        do_reset();
        req_valid = 3'b001;
        req_dr    = 9'd6;
        req_data  = 48'h0666;
        step();
        req_valid = 3'b000;
        step();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b want 1", err_underflow); end
        step();
        step();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b want 1", err_underflow); end
        do_reset();
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_cleared got %b want 0", err_underflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_valid = 1'b1;
        alloc_dr    = 3'd7;
        req_valid   = 3'b001;
        req_dr      = 9'd4;
        req_data    = 48'h5555;
        step();
        clear_inputs();
        sr1 = 3'd7;
        #1;
        checks++; if (wb_en !== 1'b1 || sr1_busy !== 1'b1) begin errors++; $display("FAIL mid_pre got en=%b busy=%b want 1 1", wb_en, sr1_busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (wb_en !== 1'b0 || wb_data !== 16'h0000 || sr1_busy !== 1'b0) begin errors++; $display("FAIL mid_dropped got en=%b data=%h busy=%b want 0 0000 0", wb_en, wb_data, sr1_busy); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        alloc_valid = 1'b1;
        alloc_dr    = 3'd4;
        req_valid   = 3'b001;
        req_dr      = 9'd4;
        req_data    = 48'hBEEF;
        step();
        clear_inputs();
        sr1 = 3'd1;
        sr2 = 3'd4;
        #1;
        checks++; if (byp2_hit !== 1'b1 || byp2_data !== 16'hBEEF) begin errors++; $display("FAIL byp2 got hit=%b data=%h want 1 beef", byp2_hit, byp2_data); end
        checks++; if (byp1_hit !== 1'b0 || sr2_busy !== 1'b1) begin errors++; $display("FAIL byp1_busy got hit1=%b busy2=%b want 0 1", byp1_hit, sr2_busy); end
        step();
        checks++; if (byp2_hit !== 1'b0) begin errors++; $display("FAIL byp2_after got %b want 0", byp2_hit); end
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_alloc_full();
        test_hazard();
        test_underflow();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
